tia_object_position_counter: RTL and testbench
==============================================

TIA_OBJECT_POSITION_COUNTER -- requirements
Module: tia_object_position_counter

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset: all state SHALL update on the rising edge of clk, and r SHALL reset it.
REQ-002 clk  input  1  color clock; all state updates on the rising edge.
REQ-003 r  input  1  synchronous active-high reset.
REQ-004 hblank  input  1  horizontal blank; while high, the normal motion clock is stopped.
REQ-005 ec_bar  input  1  active-low extra-clock request from tia_motion_registers (HMOVE extra clocks).
REQ-006 resp  input  1  object position reset strobe (RESPx write), high for one or more cycles.
REQ-007 nusiz  input  3  number/size code (000..111), sampled every cycle.
REQ-008 count  output  8  current position count, 0..159.
REQ-009 start  output  1  one-cycle pulse marking the start of an object copy.
REQ-010 scale  output  2  width scale: 0 = 1x, 1 = 2x, 2 = 4x; 3 is never driven.

Function
REQ-011 The block SHALL compute adv = (!hblank) | (!ec_bar) each cycle; there SHALL be at most one count advance per cycle, even when both terms are true.
REQ-012 If adv=1 and resp=0: count SHALL become count+1, and 159 SHALL wrap to 0.
REQ-013 If adv=0 and resp=0: count SHALL hold.
REQ-014 If resp=1: count SHALL become 0 regardless of adv or hblank; resp SHALL take priority over adv.
REQ-015 start SHALL be registered and asserted in the cycle after an advance whose new count equals an active copy offset; otherwise start SHALL be 0.
REQ-016 Copy offsets by nusiz:
  - 000: {0}
  - 001: {0,16}
  - 010: {0,32}
  - 011: {0,16,32}
  - 100: {0,64}
  - 101: {0}
  - 110: {0,32,64}
  - 111: {0}
REQ-017 Offset 0 SHALL fire only on the 159->0 wrap caused by an advance.
REQ-018 A count of 0 produced by resp SHALL NOT pulse start.
REQ-019 A held count (adv=0) SHALL NOT re-pulse start, even if the count sits on an offset.
REQ-020 scale SHALL be 1 when nusiz=101, 2 when nusiz=111, and 0 otherwise; scale SHALL be registered with one cycle of latency.
REQ-021 A nusiz change SHALL take effect on the next advance decode; a copy already pulsed SHALL NOT be retracted.
REQ-022 During HMOVE, each cycle with ec_bar=0 in hblank SHALL advance count by exactly one, so N extra clocks move the object N positions left.
REQ-023 Held resp SHALL keep count at 0 for every cycle it is high; counting SHALL resume on the first cycle after resp falls, with adv applied normally.

Reset
REQ-024 While r=1 at a clock edge: count=0, start=0, scale=0, and all internal state SHALL be cleared.
REQ-025 r SHALL override resp, adv, and nusiz.
REQ-026 r asserted mid-line SHALL abort any pending start pulse, and no start SHALL be emitted for the reset-induced count of 0.
REQ-027 On the first cycle after r falls, the block SHALL behave per REQ-011 through REQ-023 starting from count=0.

Verification
REQ-028 Free run: hblank=0, ec_bar=1, nusiz=000, 320 cycles from reset -> count reaches 159, wraps to 0; exactly 2 start pulses, one cycle after each wrap.
REQ-029 Copies: nusiz=011, one full 160-cycle line -> start pulses after count=0, 16, and 32; 3 pulses per line. nusiz=110 -> pulses at 0, 32, 64.
REQ-030 HMOVE: count=100, hblank=1, ec_bar low for 15 cycles then high, hblank held for 68 cycles total -> count=115 at hblank fall. Repeat with 8 extra clocks -> count=108.
REQ-031 resp priority: count=159, adv=1, resp=1 in the same cycle -> count=0, no start pulse; the next advance gives count=1.
REQ-032 Reset mid-operation: r pulsed at count=15 with nusiz=001 -> count=0 next cycle, no start at 16 from the aborted line; the normal pulse occurs at count=16 of the following run.
REQ-033 Scale: nusiz 101 -> scale=1 after 1 cycle; 111 -> scale=2; 000 -> scale=0; scale is never 3 across all 8 codes.

Source files
------------

// File: rtl/tia_object_position_counter_if.sv
// Signal bundle between the TIA object logic and its position counter.
// The master drives the motion controls and samples the count, start and scale results.
interface tia_object_position_counter_if;
  logic       hblank;
  logic       ec_bar;
  logic       resp;
  logic [2:0] nusiz;
  logic [7:0] count;
  logic       start;
  logic [1:0] scale;

  modport master (
    output hblank,
    output ec_bar,
    output resp,
    output nusiz,
    input  count,
    input  start,
    input  scale
  );

  modport slave (
    input  hblank,
    input  ec_bar,
    input  resp,
    input  nusiz,
    output count,
    output start,
    output scale
  );
endinterface

// File: rtl/tia_object_position_counter.sv
// Object horizontal position counter: modulo-160 count advanced by the motion clock or by
// HMOVE extra clocks, with copy-start decode driven by nusiz.
module tia_object_position_counter (
  input logic                          clk,
  input logic                          r,
  tia_object_position_counter_if.slave io_bus
);

  logic [7:0] r_count;
  logic       r_start;
  logic [1:0] r_scale;

  logic [7:0] w_count_d;
  logic       w_adv;
  logic       w_offset_hit;
  logic       w_start_d;
  logic [1:0] w_scale_d;

  always_comb begin
    w_adv     = ~io_bus.hblank | ~io_bus.ec_bar;
    w_count_d = r_count;
    if (io_bus.resp) begin
      w_count_d = 8'd0;
    end else if (w_adv) begin
      w_count_d = (r_count == 8'd159) ? 8'd0 : r_count + 8'd1;
    end
  end

  // A next count of 0 reached through an advance can only come from the 159->0 wrap.
  always_comb begin
    w_offset_hit = 1'b0;
    unique case (io_bus.nusiz)
      3'b001:  w_offset_hit = (w_count_d == 8'd0) || (w_count_d == 8'd16);
      3'b010:  w_offset_hit = (w_count_d == 8'd0) || (w_count_d == 8'd32);
      3'b011:  w_offset_hit = (w_count_d == 8'd0) || (w_count_d == 8'd16) ||
                              (w_count_d == 8'd32);
      3'b100:  w_offset_hit = (w_count_d == 8'd0) || (w_count_d == 8'd64);
      3'b110:  w_offset_hit = (w_count_d == 8'd0) || (w_count_d == 8'd32) ||
                              (w_count_d == 8'd64);
      default: w_offset_hit = (w_count_d == 8'd0);
    endcase
    w_start_d = w_adv & ~io_bus.resp & w_offset_hit;
  end

  always_comb begin
    w_scale_d = 2'd0;
    if (io_bus.nusiz == 3'b101) begin
      w_scale_d = 2'd1;
    end else if (io_bus.nusiz == 3'b111) begin
      w_scale_d = 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      r_count <= 8'd0;
      r_start <= 1'b0;
      r_scale <= 2'd0;
    end else begin
      r_count <= w_count_d;
      r_start <= w_start_d;
      r_scale <= w_scale_d;
    end
  end

  assign io_bus.count = r_count;
  assign io_bus.start = r_start;
  assign io_bus.scale = r_scale;

endmodule

// File: tb/tb_tia_object_position_counter.sv
// Scoreboard bench: the driver queues expected results per cycle, the monitor checks them on
// the falling edge.
module tb_tia_object_position_counter;

  logic clk = 1'b0;
  logic r   = 1'b1;
  always #5 clk = ~clk;

  tia_object_position_counter_if bus ();

  tia_object_position_counter dut (
    .clk    (clk),
    .r      (r),
    .io_bus (bus)
  );

  typedef struct {
    int         cyc;
    string      nm;
    bit         cc;
    logic [7:0] c;
    bit         cs;
    logic       s;
    bit         csc;
    logic [1:0] sc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   ec     = 0;
  bit   chk_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL %s missed check slot cyc=%0d now=%0d", e.nm, e.cyc, cyc);
      end else begin
        if (e.cc) begin
          n_cmp++;
          if (bus.count !== e.c) begin
            n_bad++;
            $display("FAIL %s cyc=%0d count got %0d want %0d", e.nm, cyc, bus.count, e.c);
          end
        end
        if (e.cs) begin
          n_cmp++;
          if (bus.start !== e.s) begin
            n_bad++;
            $display("FAIL %s cyc=%0d start got %b want %b", e.nm, cyc, bus.start, e.s);
          end
        end
        if (e.csc) begin
          n_cmp++;
          if (bus.scale !== e.sc) begin
            n_bad++;
            $display("FAIL %s cyc=%0d scale got %0d want %0d", e.nm, cyc, bus.scale, e.sc);
          end
        end
      end
    end
    if (chk_on) begin
      n_cmp++;
      if (bus.scale === 2'd3) begin
        n_bad++;
        $display("FAIL scale_never3 cyc=%0d scale got 3 want 0..2", cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached with %0d checks pending", sb.size());
    $fatal(1, "watchdog");
  end

  task automatic push(string nm, bit cc, logic [7:0] c, bit cs, logic s, bit csc,
                      logic [1:0] sc);
    exp_t e;
    e.cyc = cyc + 1; e.nm = nm; e.cc = cc; e.c = c; e.cs = cs; e.s = s;
    e.csc = csc; e.sc = sc;
    sb.push_back(e);
  endtask

  task automatic step(bit rst, bit hb, bit ecb, bit rsp, logic [2:0] nz);
    r          = rst;
    bus.hblank = hb;
    bus.ec_bar = ecb;
    bus.resp   = rsp;
    bus.nusiz  = nz;
    @(posedge clk);
    #1;
  endtask

  // Reset while resp and advance are active and nusiz is arbitrary: reset must win.
  task automatic do_reset(logic [2:0] nz);
    push("reset", 1'b1, 8'd0, 1'b1, 1'b0, 1'b1, 2'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, nz);
    ec = 0;
  endtask

  // Free-running advances; expected start follows the hand-listed offsets (-1 = unused).
  task automatic run(int n, logic [2:0] nz, int o1, int o2, int o3, string nm);
    for (int i = 0; i < n; i++) begin
      logic st;
      ec = (ec == 159) ? 0 : ec + 1;
      st = (ec == o1) || (ec == o2) || (ec == o3);
      push(nm, 1'b1, 8'(ec), 1'b1, st, 1'b0, 2'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, nz);
    end
  endtask

  task automatic hmove(int nx, int exp_final);
    do_reset(3'b000);
    run(100, 3'b000, 0, -1, -1, "hm_pre");
    for (int i = 0; i < 68; i++) begin
      if (i < nx) ec = ec + 1;
      push("hmove", 1'b1, (i == 67) ? 8'(exp_final) : 8'(ec), 1'b1, 1'b0, 1'b0, 2'd0);
      step(1'b0, 1'b1, (i < nx) ? 1'b0 : 1'b1, 1'b0, 3'b000);
    end
    run(1, 3'b000, 0, -1, -1, "hm_after");
  endtask

  logic [1:0] scale_tbl [8];

  initial begin
    scale_tbl = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2};
    bus.hblank = 1'b0; bus.ec_bar = 1'b1; bus.resp = 1'b0; bus.nusiz = 3'b000;
    #1;
    do_reset(3'b111);
    chk_on = 1'b1;
    do_reset(3'b000);

    run(320, 3'b000, 0, -1, -1, "freerun");
    do_reset(3'b011);
    run(160, 3'b011, 0, 16, 32, "copies011");
    do_reset(3'b110);
    run(160, 3'b110, 0, 32, 64, "copies110");

    // Held count parked on an offset must not re-pulse.
    do_reset(3'b001);
    run(16, 3'b001, 0, 16, -1, "hold_pre");
    repeat (3) begin
      push("hold_offset", 1'b1, 8'd16, 1'b1, 1'b0, 1'b0, 2'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 3'b001);
    end
    run(15, 3'b001, 0, 16, -1, "hold_post");
    push("nusiz_change", 1'b1, 8'd32, 1'b1, 1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'b010);
    ec = 32;

    hmove(15, 115);
    hmove(8, 108);

    // resp priority at the wrap point, then held resp with and without advance.
    do_reset(3'b000);
    run(159, 3'b000, 0, -1, -1, "resp_pre");
    push("resp_priority", 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 3'b000);
    ec = 0;
    run(1, 3'b000, -1, -1, -1, "resp_next");
    repeat (2) begin
      push("resp_held", 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 2'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    end
    push("resp_noadv", 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 3'b000);
    ec = 0;
    run(1, 3'b000, -1, -1, -1, "resp_resume");

    // Reset at count 15 aborts the pending copy at 16.
    do_reset(3'b001);
    run(15, 3'b001, 0, 16, -1, "rst_pre");
    push("rst_mid", 1'b1, 8'd0, 1'b1, 1'b0, 1'b1, 2'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'b001);
    ec = 0;
    push("rst_after", 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'b001);
    run(16, 3'b001, 0, 16, -1, "rst_post");

    for (int nz = 0; nz < 8; nz++) begin
      push("scale", 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, scale_tbl[nz]);
      step(1'b0, 1'b1, 1'b1, 1'b0, 3'(nz));
    end

    for (int i = 0; i < 5 && sb.size() > 0; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 3'b000);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending got %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
